// File: rtl/program_memory.sv
// Loadable instruction store: a valid/ready loader fills the RAM while the core
// is held in reset, then the core is released after a settling window.
module program_memory #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    DEPTH          = 32,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD      = 8'b11000011,
    parameter int                    RELEASE_CYCLES = 2
) (
    input  logic                  origclk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  cpu_reset,
    output logic                  loaded,
    output logic [ADDR_WIDTH:0]   program_length,
    output logic                  overflow
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [CW-1:0]       RC_L    = CW'(RELEASE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH:0]   wptr_q;
    logic [CW-1:0]         cnt_q;
    logic                  loaded_q;
    logic                  overflow_q;
    logic                  load_ready_q;
    logic                  cpu_reset_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic handshake;
    logic write_en;

    // load_ready_q is high exactly in LOAD; a same-cycle load_start wins over data
    assign handshake = load_valid & load_ready_q & ~load_start;
    assign write_en  = handshake & (wptr_q < DEPTH_L);

    always_ff @(posedge origclk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wptr_q       <= '0;
            cnt_q        <= '0;
            loaded_q     <= 1'b0;
            overflow_q   <= 1'b0;
            load_ready_q <= 1'b0;
            cpu_reset_q  <= 1'b1;
        end else if (load_start) begin
            state_q      <= S_LOAD;
            wptr_q       <= '0;
            loaded_q     <= 1'b0;
            overflow_q   <= 1'b0;
            load_ready_q <= 1'b1;
            cpu_reset_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    load_ready_q <= 1'b0;
                    cpu_reset_q  <= 1'b1;
                end
                S_LOAD: begin
                    if (handshake) begin
                        if (write_en) begin
                            wptr_q <= wptr_q + 1'b1;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                        if (load_last) begin
                            state_q      <= S_RELEASE;
                            loaded_q     <= 1'b1;
                            load_ready_q <= 1'b0;
                            cnt_q        <= RC_L;
                        end
                    end
                end
                S_RELEASE: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q <= CW'(1)) begin
                        state_q     <= S_RUN;
                        cpu_reset_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    cpu_reset_q <= 1'b0;
                end
                default: begin
                    state_q      <= S_IDLE;
                    load_ready_q <= 1'b0;
                    cpu_reset_q  <= 1'b1;
                end
            endcase
        end
    end

    // RAM contents survive reset; program_length gates every fetch instead
    always_ff @(posedge origclk) begin
        if (write_en) begin
            mem[wptr_q[IW-1:0]] <= load_data;
        end
    end

    assign instruction    = ({1'b0, pc} < wptr_q) ? mem[pc[IW-1:0]] : FILL_WORD;
    assign load_ready     = load_ready_q;
    assign cpu_reset      = cpu_reset_q;
    assign loaded         = loaded_q;
    assign program_length = wptr_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_program_memory.sv
// Random and directed loads into DEPTH=32 and DEPTH=4 stores driven in parallel,
// checked every cycle against a session-level model of the instruction store.
module tb_program_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, load_start, load_valid, load_last;
    logic [7:0] load_data, pc;

    logic [1:0] o_ready, o_cpu_reset, o_loaded, o_ovf;
    logic [8:0] o_len   [2];
    logic [7:0] o_instr [2];

    int  checks   = 0;
    int  failures = 0;
    bit  started  = 1'b0;

    program_memory #(.DEPTH(32)) u_dut0 (
        .origclk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(o_ready[0]), .pc(pc),
        .instruction(o_instr[0]), .cpu_reset(o_cpu_reset[0]), .loaded(o_loaded[0]),
        .program_length(o_len[0]), .overflow(o_ovf[0])
    );

    program_memory #(.DEPTH(4)) u_dut4 (
        .origclk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(o_ready[1]), .pc(pc),
        .instruction(o_instr[1]), .cpu_reset(o_cpu_reset[1]), .loaded(o_loaded[1]),
        .program_length(o_len[1]), .overflow(o_ovf[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: session mode (0 idle, 1 loading, 2 settling, 3 running), image length,
    // flags, and the edge number at which the core is released.
    int      m_mode [2];
    int      m_len  [2];
    bit      m_loaded [2];
    bit      m_ovf  [2];
    logic [7:0] m_mem [2][256];
    longint  cyc;
    longint  m_release_at [2];

    function automatic int depth_of(input int d);
        return (d == 0) ? 32 : 4;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                m_mode[d] = 0; m_len[d] = 0; m_loaded[d] = 0; m_ovf[d] = 0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (load_start) begin
                    m_mode[d] = 1; m_len[d] = 0; m_loaded[d] = 0; m_ovf[d] = 0;
                end else if (m_mode[d] == 1) begin
                    if (load_valid) begin
                        if (m_len[d] < depth_of(d)) begin
                            m_mem[d][m_len[d]] = load_data;
                            m_len[d]++;
                        end else begin
                            m_ovf[d] = 1;
                        end
                        if (load_last) begin
                            m_loaded[d]     = 1;
                            m_mode[d]       = 2;
                            m_release_at[d] = cyc + 2;
                        end
                    end
                end else if (m_mode[d] == 2 && cyc >= m_release_at[d]) begin
                    m_mode[d] = 3;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("i%0d_load_ready", d), {31'b0, o_ready[d]}, {31'b0, m_mode[d] == 1});
                check($sformatf("i%0d_cpu_reset", d), {31'b0, o_cpu_reset[d]}, {31'b0, m_mode[d] != 3});
                check($sformatf("i%0d_loaded", d), {31'b0, o_loaded[d]}, {31'b0, m_loaded[d]});
                check($sformatf("i%0d_overflow", d), {31'b0, o_ovf[d]}, {31'b0, m_ovf[d]});
                check($sformatf("i%0d_length", d), {23'b0, o_len[d]}, m_len[d]);
                check($sformatf("i%0d_instr_pc%0d", d, pc), {24'b0, o_instr[d]},
                      {24'b0, (int'(pc) < m_len[d]) ? m_mem[d][pc] : 8'hC3});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        pc = 8'($urandom_range(0, 40));
    endtask

    task automatic start_session(input bit with_valid);
        load_start = 1'b1;
        load_valid = with_valid;
        load_data  = 8'hAA;
        load_last  = 1'b0;
        step();
        load_start = 1'b0;
        load_valid = 1'b0;
        $display("txn start_session same_cycle_valid=%0d", with_valid);
    endtask

    task automatic send_word(input logic [7:0] data, input bit last, input bit gaps);
        int g = 0;
        while (gaps && g < 5 && $urandom_range(0, 2) == 0) begin
            load_valid = 1'b0;
            load_last  = 1'($urandom_range(0, 1));
            load_data  = 8'($urandom);
            step();
            g++;
        end
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        $display("txn word data=%02h last=%0d gaps=%0d", data, last, g);
    endtask

    task automatic wait_run();
        int n = 0;
        while (!(o_cpu_reset[0] == 1'b0 && o_cpu_reset[1] == 1'b0) && n < 20) begin
            step();
            n++;
        end
        check("wait_run_timeout", {31'b0, o_cpu_reset[0] | o_cpu_reset[1]}, 32'd0);
    endtask

    task automatic probe(input logic [7:0] addr, input int d, input logic [7:0] exp, input string nm);
        @(negedge clk);
        #1 pc = addr;
        #1 check(nm, {24'b0, o_instr[d]}, {24'b0, exp});
    endtask

    logic [7:0] pat [4] = '{8'h44, 8'h49, 8'h19, 8'h84};

    initial begin
        reset = 1'b1; load_start = 1'b0; load_valid = 1'b0;
        load_data = 8'h00; load_last = 1'b0; pc = 8'h00; cyc = 0;
        @(posedge clk);
        started = 1'b1;
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;

        // reset only
        @(negedge clk);
        check("rst_cpu_reset", {31'b0, o_cpu_reset[0]}, 32'd1);
        check("rst_loaded", {31'b0, o_loaded[0]}, 32'd0);
        check("rst_length", {23'b0, o_len[0]}, 32'd0);
        probe(8'd0, 0, 8'hC3, "rst_instr_pc0");
        probe(8'd5, 0, 8'hC3, "rst_instr_pc5");
        probe(8'd255, 0, 8'hC3, "rst_instr_pc255");
        step();

        // normal load of 21 words
        start_session(1'b0);
        for (int i = 0; i < 21; i++) begin
            send_word((i == 20) ? 8'hC3 : pat[i % 4], i == 20, 1'b0);
        end
        @(negedge clk);
        check("norm_cpu_reset_k", {31'b0, o_cpu_reset[0]}, 32'd1);
        @(negedge clk);
        check("norm_cpu_reset_k1", {31'b0, o_cpu_reset[0]}, 32'd1);
        @(negedge clk);
        check("norm_cpu_reset_k2", {31'b0, o_cpu_reset[0]}, 32'd0);
        check("norm_length", {23'b0, o_len[0]}, 32'd21);
        check("norm_loaded", {31'b0, o_loaded[0]}, 32'd1);
        check("norm_d4_length", {23'b0, o_len[1]}, 32'd4);
        check("norm_d4_overflow", {31'b0, o_ovf[1]}, 32'd1);
        probe(8'd2, 0, 8'h19, "norm_instr_pc2");
        probe(8'd21, 0, 8'hC3, "norm_instr_pc21");
        probe(8'd3, 1, 8'h84, "norm_d4_instr_pc3");
        step();

        // backpressure and gaps
        start_session(1'b0);
        for (int i = 0; i < 4; i++) send_word(8'($urandom), i == 3, 1'b1);
        check("bp_length", {23'b0, o_len[0]}, 32'd4);
        wait_run();

        // overflow: six words into the DEPTH=4 store
        start_session(1'b0);
        for (int i = 0; i < 6; i++) send_word(8'h10 + 8'(i), i == 5, 1'b1);
        check("ovf_length", {23'b0, o_len[1]}, 32'd4);
        check("ovf_flag", {31'b0, o_ovf[1]}, 32'd1);
        check("ovf_d32_length", {23'b0, o_len[0]}, 32'd6);
        probe(8'd4, 1, 8'hC3, "ovf_instr_pc4");
        probe(8'd5, 1, 8'hC3, "ovf_instr_pc5");
        probe(8'd5, 0, 8'h15, "ovf_d32_instr_pc5");
        wait_run();

        // reload from RUN with a same-cycle data word
        start_session(1'b1);
        check("reload_cpu_reset", {31'b0, o_cpu_reset[0]}, 32'd1);
        check("reload_length", {23'b0, o_len[0]}, 32'd0);
        check("reload_overflow", {31'b0, o_ovf[1]}, 32'd0);
        probe(8'd0, 0, 8'hC3, "reload_instr_pc0");
        send_word(8'h5A, 1'b0, 1'b1);
        send_word(8'hA5, 1'b1, 1'b1);
        wait_run();

        // mid-load reset after three accepted words
        start_session(1'b0);
        for (int i = 0; i < 3; i++) send_word(8'($urandom), 1'b0, 1'b0);
        load_valid = 1'b1;
        reset = 1'b1;
        #1;
        check("mid_rst_length", {23'b0, o_len[0]}, 32'd0);
        check("mid_rst_ready", {31'b0, o_ready[0]}, 32'd0);
        check("mid_rst_cpu_reset", {31'b0, o_cpu_reset[0]}, 32'd1);
        step();
        reset = 1'b0;
        repeat (5) step();
        load_valid = 1'b0;
        check("idle_hold_length", {23'b0, o_len[0]}, 32'd0);
        check("idle_hold_ready", {31'b0, o_ready[0]}, 32'd0);

        // random sessions
        for (int s = 0; s < 4; s++) begin
            int n = $urandom_range(1, 8);
            start_session(1'($urandom_range(0, 1)));
            for (int i = 0; i < n; i++) send_word(8'($urandom), i == n - 1, 1'b1);
            wait_run();
            repeat (3) step();
        end

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
